// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Op codes and the per-level stage register bundle.
package shift_pkg;

    localparam int MAXW = 64;
    localparam int MAXA = 6;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // Sized for the widest legal WIDTH; narrower builds use the low bits.
    typedef struct packed {
        logic            valid;
        op_e             op;
        logic [MAXA-1:0] amt;
        logic [MAXW-1:0] data;
    } stage_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: conditional shift by SHIFT plus elastic register.
// Rotate support is compiled in by PIPE_SHIFTER_ROTATE_EN.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   flush,
    input  stage_t up,
    output logic   ready,
    input  logic   down_ready,
    output stage_t q
);

    localparam int LVL = $clog2(SHIFT);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] res;
    logic             unused_bits;

    assign d           = up.data[WIDTH-1:0];
    assign unused_bits = ^{up.data, up.amt};

    // Register can take a new entry when empty or when it drains this cycle.
    assign ready = !q.valid || down_ready;

    // Shift by this level's weight when its amount bit is set.
    always_comb begin
        res = d;
        unique case (up.op)
            OP_SLL: if (up.amt[LVL]) res = d << SHIFT;
            OP_SRL: if (up.amt[LVL]) res = d >> SHIFT;
            OP_SRA: if (up.amt[LVL]) res = $signed(d) >>> SHIFT;
`ifdef PIPE_SHIFTER_ROTATE_EN
            OP_ROR: if (up.amt[LVL]) res = {d[SHIFT-1:0], d[WIDTH-1:SHIFT]};
`else
            OP_ROR: res = '0;
`endif
            default: res = d;
        endcase
    end

    // Stage register: reset beats flush, flush beats a load.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (ready) begin
            q.valid <= up.valid;
            if (up.valid) begin
                q.op   <= up.op;
                q.amt  <= up.amt;
                q.data <= MAXW'(res);
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Elastic pipelined barrel shifter, one register per shift level.
// Define PIPE_SHIFTER_ROTATE_EN to enable the ROR operation.
module pipe_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AMTW  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_t [AMTW:0] st;
    logic   [AMTW:0] rdy;
    logic            unused_tail;

    assign st[0].valid = in_valid;
    assign st[0].op    = op_e'(in_op);
    assign st[0].amt   = MAXA'(in_amt);
    assign st[0].data  = MAXW'(in_data);

    assign rdy[AMTW] = out_ready;

    // Nothing enters while the pipe is being cleared.
    assign in_ready = rdy[0] && !flush && !reset;

    assign out_valid   = st[AMTW].valid;
    assign out_data    = st[AMTW].data[WIDTH-1:0];
    assign unused_tail = ^{st[AMTW].data, st[AMTW].amt, st[AMTW].op};

    for (genvar k = 0; k < AMTW; k++) begin : g_lvl
        shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush),
            .up         (st[k]),
            .ready      (rdy[k]),
            .down_ready (rdy[k+1]),
            .q          (st[k+1])
        );
    end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; power of two, 4..64.
REQ-002 Parameter AMTW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 Port clock  input  1  sole clock; all state on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port flush  input  1  synchronous discard of all in-flight operations.
REQ-006 Port in_valid  input  1  request present.
REQ-007 Port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 Port in_op  input  2  operation code (SLL=00, SRL=01, SRA=10, ROR=11).
REQ-009 Port in_data  input  WIDTH  operand.
REQ-010 Port in_amt  input  AMTW  shift amount, 0..WIDTH-1.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 Port out_data  output  WIDTH  result.

Function
REQ-014 Datapath SHALL be AMTW levels; level k conditionally shifts by 2^k under in_amt[k], LSB level first.
REQ-015 Each level SHALL be followed by a register holding data, remaining amount bits, op and a valid bit; latency from acceptance to out_valid = AMTW cycles (5 at WIDTH=32).
REQ-016 SLL SHALL fill vacated LSBs with 0; SRL SHALL fill vacated MSBs with 0; SRA SHALL fill vacated MSBs with in_data[WIDTH-1].
REQ-017 in_amt=0 SHALL return in_data unchanged for every op.
REQ-018 Pipeline SHALL be elastic: stage k advances when its successor is empty or advancing; last stage advances on out_ready.
REQ-019 in_ready SHALL equal (stage 0 empty) || (stage 0 advancing); throughput one op per cycle when out_ready held high.
REQ-020 With out_valid high and out_ready low, out_data and out_valid SHALL hold stable; no result lost or duplicated.
REQ-021 Results SHALL emerge in acceptance order.
REQ-022 flush SHALL clear every stage valid bit at the edge; a request presented in the same cycle SHALL NOT be accepted (in_ready low while flush high).
REQ-023 Simultaneous last-stage output handshake and flush: the output transfer completes, then the stage clears.

Reset
REQ-024 On reset, all valid bits SHALL clear; out_valid=0, out_data=0, in_ready=0 during the reset cycle, in_ready=1 the cycle after.
REQ-025 reset SHALL take priority over flush and over any handshake; reset mid-operation discards all in-flight results.
REQ-026 Data registers SHALL reset to 0.

Configuration
REQ-027 Macro PIPE_SHIFTER_ROTATE_EN SHALL compile in the ROR operation (rotate right, bits leaving LSB re-enter at MSB).
REQ-028 Without PIPE_SHIFTER_ROTATE_EN, op 11 SHALL be accepted and produce out_data=0 with normal latency.

Structure
REQ-029 Package shift_pkg SHALL hold the op-code enum (OP_SLL, OP_SRL, OP_SRA, OP_ROR) and the stage-register struct.
REQ-030 Sub-module shift_stage (parameter SHIFT=2^k) SHALL implement one level: combinational shift plus its elastic register; pipe_shifter instantiates AMTW of them via generate.

Verification
REQ-031 SLL 0x0000_0001 amt 31 -> 0x8000_0000 after 5 cycles; SRL 0x8000_0000 amt 4 -> 0x0800_0000.
REQ-032 SRA 0x8000_00F0 amt 4 -> 0xF800_000F; SRA 0x7000_0000 amt 28 -> 0x0000_0007.
REQ-033 ROR 0x0000_00FF amt 4 -> 0xF000_000F with macro; 0x0000_0000 without.
REQ-034 Back-to-back 8 ops, out_ready low cycles 3..6 -> all 8 results in order, out_data stable while stalled, in_ready low once full.
REQ-035 Flush with 3 ops in flight -> no out_valid for them; next op accepted the following cycle returns correct result after 5 cycles.
REQ-036 Reset asserted with pipeline full and out_valid high -> out_valid=0 next cycle, out_data=0, no stale result emerges afterwards.
